// File: rtl/ls_counter_n_if.sv
// ls_counter_n_if: interface bundling the data/control/status signals of ls_counter_n.
//   Configuration macro: LS_COUNTER_WRAPCNT_EN adds the WRAPS wrap-event counter.
//   D        parallel load value            (master -> slave)
//   LOAD_n   synchronous load, active low   (master -> slave)
//   ENP      parallel count enable          (master -> slave)
//   ENT      trickle count enable           (master -> slave)
//   UP       1 = count up, 0 = count down   (master -> slave)
//   LIMIT    terminal value, range 0..LIMIT (master -> slave)
//   Q        counter value                  (slave -> master)
//   RCO      ripple carry, ENT & terminal   (slave -> master)
//   TC_PULSE registered wrap pulse          (slave -> master)
//   WRAPS    saturating wrap count          (slave -> master, macro only)
interface ls_counter_n_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WRAPW = 8
);
  logic [WIDTH-1:0] D;
  logic             LOAD_n;
  logic             ENP;
  logic             ENT;
  logic             UP;
  logic [WIDTH-1:0] LIMIT;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             TC_PULSE;
`ifdef LS_COUNTER_WRAPCNT_EN
  logic [WRAPW-1:0] WRAPS;
`endif

  if (WIDTH < 1) begin : g_bad_width
    $error("ls_counter_n_if: WIDTH must be >= 1");
  end
  if (WRAPW < 1) begin : g_bad_wrapw
    $error("ls_counter_n_if: WRAPW must be >= 1");
  end

  modport master (
    output D, LOAD_n, ENP, ENT, UP, LIMIT,
    input  Q, RCO, TC_PULSE
`ifdef LS_COUNTER_WRAPCNT_EN
    , input WRAPS
`endif
  );

  modport slave (
    input  D, LOAD_n, ENP, ENT, UP, LIMIT,
    output Q, RCO, TC_PULSE
`ifdef LS_COUNTER_WRAPCNT_EN
    , output WRAPS
`endif
  );
endinterface

// File: rtl/ls_counter_n.sv
// ls_counter_n: parametrised cascadable synchronous up/down counter with a
// programmable terminal value (LIMIT), combinational ripple carry and a
// registered one-cycle wrap pulse.
//   Configuration macro: LS_COUNTER_WRAPCNT_EN adds a saturating wrap-event
//   counter on bus.WRAPS (cleared by reset and by a parallel load).
// Ports:
//   CLK    rising-edge clock
//   CLR_n  asynchronous active-low reset
//   bus    ls_counter_n_if.slave: D, LOAD_n, ENP, ENT, UP, LIMIT in;
//          Q, RCO, TC_PULSE (and WRAPS) out
// Cascading: drive ENT of the next stage from RCO of this stage, shared CLK.
module ls_counter_n #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WRAPW = 8
) (
  input  logic          CLK,
  input  logic          CLR_n,
  ls_counter_n_if.slave bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("ls_counter_n: WIDTH must be >= 1");
  end
  if (WRAPW < 1) begin : g_bad_wrapw
    $error("ls_counter_n: WRAPW must be >= 1");
  end

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic             terminal;
  logic             cnt_en;
  logic             wrap;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    terminal = bus.UP ? (q_r == bus.LIMIT) : (q_r == '0);
    cnt_en   = bus.ENP & bus.ENT;
    // Up-count from above LIMIT (only reachable by a load) also lands on 0,
    // so it is treated as a wrap even though terminal was not asserted.
    // Down-count from above LIMIT lands on LIMIT and is not a wrap.
    wrap     = cnt_en & (bus.UP ? (q_r >= bus.LIMIT) : (q_r == '0));
    q_next   = q_r;
    if (bus.UP) begin
      q_next = (q_r >= bus.LIMIT) ? '0 : q_r + 1'b1;
    end else begin
      q_next = ((q_r == '0) || (q_r > bus.LIMIT)) ? bus.LIMIT : q_r - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      q_r  <= '0;
      tc_r <= 1'b0;
    end else if (!bus.LOAD_n) begin
      q_r  <= bus.D;
      tc_r <= 1'b0;
    end else begin
      tc_r <= wrap;
      if (cnt_en) begin
        q_r <= q_next;
      end
    end
  end

`ifdef LS_COUNTER_WRAPCNT_EN
  logic [WRAPW-1:0] wraps_r;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      wraps_r <= '0;
    end else if (!bus.LOAD_n) begin
      wraps_r <= '0;
    end else if (wrap && (wraps_r != '1)) begin
      wraps_r <= wraps_r + 1'b1;
    end
  end

  assign bus.WRAPS = wraps_r;
`endif

  assign bus.Q        = q_r;
  assign bus.TC_PULSE = tc_r;
  assign bus.RCO      = bus.ENT & terminal;

endmodule

// File: tb/tb_ls_counter_n.sv
// tb_ls_counter_n: directed self-checking bench for ls_counter_n (WIDTH=4).
// A second instance (u_hi) is cascaded from u_dut's RCO for the 8-bit chain.
module tb_ls_counter_n;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned WRAPW = 8;

  logic CLK;
  logic CLR_n;

  int unsigned n_checks;
  int unsigned n_errors;

  ls_counter_n_if #(.WIDTH(WIDTH), .WRAPW(WRAPW)) bus ();
  ls_counter_n_if #(.WIDTH(WIDTH), .WRAPW(WRAPW)) hi_bus ();

  ls_counter_n #(.WIDTH(WIDTH), .WRAPW(WRAPW)) u_dut (
    .CLK   (CLK),
    .CLR_n (CLR_n),
    .bus   (bus.slave)
  );

  ls_counter_n #(.WIDTH(WIDTH), .WRAPW(WRAPW)) u_hi (
    .CLK   (CLK),
    .CLR_n (CLR_n),
    .bus   (hi_bus.slave)
  );

  assign hi_bus.ENT = bus.RCO;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before inputs change or outputs are sampled.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] val);
    bus.LOAD_n = 1'b0;
    bus.D      = val;
    tick();
    bus.LOAD_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    CLR_n      = 1'b0;
    bus.D      = '0;
    bus.LOAD_n = 1'b1;
    bus.ENP    = 1'b0;
    bus.ENT    = 1'b0;
    bus.UP     = 1'b1;
    bus.LIMIT  = 4'd15;
    hi_bus.D      = '0;
    hi_bus.LOAD_n = 1'b1;
    hi_bus.ENP    = 1'b0;
    hi_bus.UP     = 1'b1;
    hi_bus.LIMIT  = 4'd15;
    #2;

    // Reset state and RCO following its equation during reset.
    check("rst_q", bus.Q, 0);
    check("rst_tc", bus.TC_PULSE, 0);
    check("rst_rco_up", bus.RCO, 0);
`ifdef LS_COUNTER_WRAPCNT_EN
    check("rst_wraps", bus.WRAPS, 0);
`endif
    bus.UP  = 1'b0;
    bus.ENT = 1'b1;
    #1;
    check("rst_rco_down", bus.RCO, 1);
    bus.UP  = 1'b1;
    bus.ENT = 1'b0;

    // T1: async clear mid-count, then full 0..15 range.
    @(negedge CLK);
    CLR_n = 1'b1;
    load(4'd7);
    check("t1_load7", bus.Q, 7);
    bus.ENP = 1'b1;
    bus.ENT = 1'b1;
    #1;
    CLR_n = 1'b0;
    #1;
    check("t1_async_q", bus.Q, 0);
    check("t1_async_tc", bus.TC_PULSE, 0);
    #1;
    CLR_n = 1'b1;
    check("t1_rco0", bus.RCO, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("t1_q", bus.Q, i);
      check("t1_rco", bus.RCO, (i == 15) ? 1 : 0);
      check("t1_tc", bus.TC_PULSE, 0);
    end
    tick();
    check("t1_wrap_q", bus.Q, 0);
    check("t1_wrap_tc", bus.TC_PULSE, 1);
    tick();
    check("t1_post_q", bus.Q, 1);
    check("t1_post_tc", bus.TC_PULSE, 0);

    // T2: decade counter, ENT drop at the terminal value.
    bus.LIMIT = 4'd9;
    load(4'd0);
    check("t2_load_tc", bus.TC_PULSE, 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("t2_q", bus.Q, i);
      check("t2_rco", bus.RCO, (i == 9) ? 1 : 0);
    end
    bus.ENT = 1'b0;
    #1;
    check("t2_rco_ent0", bus.RCO, 0);
    tick();
    check("t2_hold_q", bus.Q, 9);
    check("t2_hold_tc", bus.TC_PULSE, 0);
    bus.ENT = 1'b1;
    #1;
    check("t2_rco_ent1", bus.RCO, 1);
    tick();
    check("t2_wrap_q", bus.Q, 0);
    check("t2_wrap_tc", bus.TC_PULSE, 1);

    // T3: load wins over count; out-of-range recovery both directions.
    load(4'd12);
    check("t3_load_q", bus.Q, 12);
    check("t3_load_tc", bus.TC_PULSE, 0);
    check("t3_rco", bus.RCO, 0);
    tick();
    check("t3_up_q", bus.Q, 0);
    check("t3_up_tc", bus.TC_PULSE, 1);
    load(4'd12);
    bus.UP = 1'b0;
    tick();
    check("t3_dn_q", bus.Q, 9);
    check("t3_dn_tc", bus.TC_PULSE, 0);

    // T4: down count with LIMIT=5.
    bus.LIMIT = 4'd5;
    load(4'd2);
    tick();
    check("t4_q1", bus.Q, 1);
    check("t4_rco1", bus.RCO, 0);
    tick();
    check("t4_q0", bus.Q, 0);
    check("t4_rco0", bus.RCO, 1);
    check("t4_tc0", bus.TC_PULSE, 0);
    tick();
    check("t4_q5", bus.Q, 5);
    check("t4_tc5", bus.TC_PULSE, 1);
    tick();
    check("t4_q4", bus.Q, 4);
    check("t4_tc4", bus.TC_PULSE, 0);

    // ENP low: hold, no pulse.
    bus.ENP = 1'b0;
    tick();
    check("hold_q", bus.Q, 4);
    check("hold_tc", bus.TC_PULSE, 0);
    bus.ENP = 1'b1;

    // LIMIT=0: every enabled cycle wraps, pulse stays high.
    bus.UP    = 1'b1;
    bus.LIMIT = 4'd0;
    load(4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lim0_q", bus.Q, 0);
      check("lim0_tc", bus.TC_PULSE, 1);
    end

    // LIMIT=all-ones, down from 0 wraps to 15.
    bus.UP    = 1'b0;
    bus.LIMIT = 4'd15;
    load(4'd0);
    tick();
    check("full_dn_q", bus.Q, 15);
    check("full_dn_tc", bus.TC_PULSE, 1);

    // T5: two-stage cascade runs 0x00..0xFF,0x00.
    @(negedge CLK);
    CLR_n = 1'b0;
    #1;
    CLR_n      = 1'b1;
    bus.UP     = 1'b1;
    bus.LIMIT  = 4'd15;
    bus.ENP    = 1'b1;
    bus.ENT    = 1'b1;
    hi_bus.ENP = 1'b1;
    check("t5_start", {hi_bus.Q, bus.Q}, 0);
    for (int i = 1; i <= 256; i++) begin
      tick();
      check("t5_chain", {hi_bus.Q, bus.Q}, i % 256);
    end
    hi_bus.ENP = 1'b0;

`ifdef LS_COUNTER_WRAPCNT_EN
    // T6: wrap counter saturation and clear on load.
    bus.LIMIT = 4'd0;
    load(4'd0);
    check("t6_load_wraps", bus.WRAPS, 0);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 1 || i == 254 || i == 255 || i == 300) begin
        check("t6_wraps", bus.WRAPS, (i > 255) ? 255 : i);
      end
    end
    load(4'd0);
    check("t6_clear_wraps", bus.WRAPS, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
